// File: rtl/regfile_pkg.sv
// Purpose : shared constants and types for the 16-bit core register file.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int          REG_W     = 16;
    localparam int          REG_DEPTH = 16;
    localparam int          SP_IDX    = 13;
    localparam logic [15:0] SP_INIT   = 16'h01FF;

    typedef logic [3:0]  reg_addr_t;
    typedef logic [15:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Purpose : per-register pending-write bits; issue sets, writeback clears, set beats clear.
// Latency : busy updates one cycle after issue/clear; busy_cleared is combinational.
// Backpressure: none; every issue and clear is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst_n             clock and async active-low reset
//   issue_en, issue_addr   mark a destination register as awaiting writeback
//   clr_en, clr_addr       two writeback ports, each clears its addressed bit
//   busy                   registered pending vector
//   busy_cleared           busy with this cycle's clears applied, issue ignored
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic [1:0]        clr_en,
    input  logic [2*AW-1:0]   clr_addr,
    output logic [DEPTH-1:0]  busy,
    output logic [DEPTH-1:0]  busy_cleared
);

    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] set_mask;

    always_comb begin
        clr_mask = '0;
        for (int j = 0; j < 2; j++) begin
            if (clr_en[j]) begin
                clr_mask[clr_addr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        set_mask = '0;
        if (issue_en) begin
            set_mask[issue_addr] = 1'b1;
        end
    end

    assign busy_cleared = busy & ~clr_mask;

    // OR-ing the set after the clear makes a same-cycle issue win: the newer
    // instruction is still outstanding even though an older one wrote back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_cleared | set_mask;
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_nr2w.sv
// Purpose : NUM_RD-read / 2-write register file with optional write bypass and hazard scoreboard.
// Latency : reads 1 cycle (registered outputs), writes visible to array reads the next cycle.
// Backpressure: none; ports are always ready, rd_en_i=0 holds the last read result.
//
// Ports:
//   clk_i, reset_n_i          clock and async active-low reset
//   rd_en_i/rd_addr_i         per-port read enable and packed addresses
//   rd_data_o/rd_pend_o       per-port registered data and pending-write flag
//   wr_en_i/wr_addr_i/wr_data_i  two packed write ports, port 1 has priority
//   issue_en_i/issue_addr_i   mark a destination register as pending
//   busy_o                    registered pending vector
module regfile_nr2w
    import regfile_pkg::*;
#(
    parameter int          WIDTH   = REG_W,
    parameter int          DEPTH   = REG_DEPTH,
    parameter int          NUM_RD  = 2,
    parameter int          SP_IDX  = regfile_pkg::SP_IDX,
    parameter logic [15:0] SP_INIT = regfile_pkg::SP_INIT,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]        rd_pend_o,
    input  logic [1:0]               wr_en_i,
    input  logic [2*$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [2*WIDTH-1:0]       wr_data_i,
    input  logic                     issue_en_i,
    input  logic [$clog2(DEPTH)-1:0] issue_addr_i,
    output logic [DEPTH-1:0]         busy_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];

    logic [AW-1:0]    wr_addr0;
    logic [AW-1:0]    wr_addr1;
    logic [WIDTH-1:0] wr_data0;
    logic [WIDTH-1:0] wr_data1;

    assign wr_addr0 = wr_addr_i[0  +: AW];
    assign wr_addr1 = wr_addr_i[AW +: AW];
    assign wr_data0 = wr_data_i[0     +: WIDTH];
    assign wr_data1 = wr_data_i[WIDTH +: WIDTH];

    // Registers below SP hold their own index after reset, which gives
    // software a recognisable pattern; SP gets its boot stack pointer.
    function automatic logic [WIDTH-1:0] reset_val(input int idx);
        if (idx < SP_IDX) begin
            return WIDTH'(idx);
        end else if (idx == SP_IDX) begin
            return WIDTH'(SP_INIT);
        end else begin
            return '0;
        end
    endfunction

    // ------------------------------------------------------------------
    // Register array: port 1 overrides port 0 on an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= reset_val(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en_i[1] && (wr_addr1 == AW'(i))) begin
                    regs[i] <= wr_data1;
                end else if (wr_en_i[0] && (wr_addr0 == AW'(i))) begin
                    regs[i] <= wr_data0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_cleared;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk          (clk_i),
        .rst_n        (reset_n_i),
        .issue_en     (issue_en_i),
        .issue_addr   (issue_addr_i),
        .clr_en       (wr_en_i),
        .clr_addr     (wr_addr_i),
        .busy         (busy),
        .busy_cleared (busy_cleared)
    );

    assign busy_o = busy;

    // ------------------------------------------------------------------
    // Read ports.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data_nxt;
        logic             pend_nxt;
        logic [WIDTH-1:0] data_q;
        logic             pend_q;

        assign addr = rd_addr_i[k*AW +: AW];

        if (BYPASS) begin : g_byp
            // Forward same-cycle write data with the same priority the array
            // uses, so a bypassed read always matches what gets stored.
            always_comb begin
                data_nxt = regs[addr];
                if (wr_en_i[1] && (wr_addr1 == addr)) begin
                    data_nxt = wr_data1;
                end else if (wr_en_i[0] && (wr_addr0 == addr)) begin
                    data_nxt = wr_data0;
                end
            end
            // The forwarded data already reflects the writeback, so the
            // pending flag must too; a same-cycle issue is for a later value.
            assign pend_nxt = busy_cleared[addr];
        end else begin : g_nobyp
            assign data_nxt = regs[addr];
            assign pend_nxt = busy[addr];
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                data_q <= '0;
                pend_q <= 1'b0;
            end else if (rd_en_i[k]) begin
                data_q <= data_nxt;
                pend_q <= pend_nxt;
            end
        end

        assign rd_data_o[k*WIDTH +: WIDTH] = data_q;
        assign rd_pend_o[k]                = pend_q;
    end

endmodule : regfile_nr2w

// File: tb/tb_regfile_nr2w.sv
// Purpose : directed, table-driven check of regfile_nr2w with BYPASS=1 and BYPASS=0 side by side.
// Latency : each vector is applied for one clock and checked 1 time unit after the edge.
// Backpressure: n/a.
module tb_regfile_nr2w;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rd_en = '0;
    logic [7:0]  rd_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [3:0]  issue_addr = '0;

    logic [31:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_pend_b, rd_pend_n;
    logic [15:0] busy_b, busy_n;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_nr2w #(.BYPASS(1'b1)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_b), .rd_pend_o(rd_pend_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .busy_o(busy_b)
    );

    regfile_nr2w #(.BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .reset_n_i(reset_n),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_n), .rd_pend_o(rd_pend_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .busy_o(busy_n)
    );

    typedef struct {
        logic [1:0] re;
        reg_addr_t  ra0, ra1;
        logic [1:0] we;
        reg_addr_t  wa0;
        reg_data_t  wd0;
        reg_addr_t  wa1;
        reg_data_t  wd1;
        reg_data_t  e0, e1;   // expected data, BYPASS=1
        reg_data_t  n0, n1;   // expected data, BYPASS=0
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(
        input logic [1:0] re, input reg_addr_t ra0, input reg_addr_t ra1,
        input logic [1:0] we, input reg_addr_t wa0, input reg_data_t wd0,
        input reg_addr_t wa1, input reg_data_t wd1,
        input reg_data_t e0, input reg_data_t e1,
        input reg_data_t n0, input reg_data_t n1);
        vec_t v;
        v.re = re; v.ra0 = ra0; v.ra1 = ra1;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.e0 = e0; v.e1 = e1; v.n0 = n0; v.n1 = n1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = '0; wr_en = '0; issue_en = 1'b0;
    endtask

    initial begin
        // Reset state and power-on contents, read as pairs (k, k+8).
        vecs[0]  = mk(2'b11, 4'd0, 4'd8,  2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0000, 16'h0008, 16'h0000, 16'h0008);
        vecs[1]  = mk(2'b11, 4'd1, 4'd9,  2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0001, 16'h0009, 16'h0001, 16'h0009);
        vecs[2]  = mk(2'b11, 4'd2, 4'd10, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0002, 16'h000A, 16'h0002, 16'h000A);
        vecs[3]  = mk(2'b11, 4'd3, 4'd11, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0003, 16'h000B, 16'h0003, 16'h000B);
        vecs[4]  = mk(2'b11, 4'd4, 4'd12, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0004, 16'h000C, 16'h0004, 16'h000C);
        vecs[5]  = mk(2'b11, 4'd5, 4'd13, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0005, 16'h01FF, 16'h0005, 16'h01FF);
        vecs[6]  = mk(2'b11, 4'd6, 4'd14, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0006, 16'h0000, 16'h0006, 16'h0000);
        vecs[7]  = mk(2'b11, 4'd7, 4'd15, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0007, 16'h0000, 16'h0007, 16'h0000);
        // Same-address double write, no read: outputs hold.
        vecs[8]  = mk(2'b00, 4'd0, 4'd0, 2'b11, 4'd3, 16'hAAAA, 4'd3, 16'h5555, 16'h0007, 16'h0000, 16'h0007, 16'h0000);
        vecs[9]  = mk(2'b11, 4'd3, 4'd3, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
        // Write/read collision on addr 5.
        vecs[10] = mk(2'b11, 4'd5, 4'd5, 2'b01, 4'd5, 16'h1234, 4'd0, 16'h0, 16'h1234, 16'h1234, 16'h0005, 16'h0005);
        vecs[11] = mk(2'b11, 4'd5, 4'd5, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
        // Port-1 bypass, port 1 reading an unrelated register.
        vecs[12] = mk(2'b11, 4'd7, 4'd6, 2'b10, 4'd0, 16'h0, 4'd7, 16'hBEEF, 16'hBEEF, 16'h0006, 16'h0007, 16'h0006);
        vecs[13] = mk(2'b11, 4'd7, 4'd7, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        // Read disabled for 3 cycles while addr 7 is overwritten: hold.
        vecs[14] = mk(2'b00, 4'd7, 4'd7, 2'b01, 4'd7, 16'h0000, 4'd0, 16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        vecs[15] = mk(2'b00, 4'd7, 4'd7, 2'b01, 4'd7, 16'h0000, 4'd0, 16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        vecs[16] = mk(2'b00, 4'd7, 4'd7, 2'b01, 4'd7, 16'h0000, 4'd0, 16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        vecs[17] = mk(2'b11, 4'd7, 4'd7, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // Two writes to different addresses are both stored.
        vecs[18] = mk(2'b00, 4'd0, 4'd0, 2'b11, 4'd10, 16'h0A0A, 4'd11, 16'h0B0B, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        vecs[19] = mk(2'b11, 4'd10, 4'd11, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0A0A, 16'h0B0B, 16'h0A0A, 16'h0B0B);
        // Only port 0 enabled: port 1 holds.
        vecs[20] = mk(2'b01, 4'd0, 4'd3, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0000, 16'h0B0B, 16'h0000, 16'h0B0B);
        // Double write + bypass read: port 1 data is forwarded.
        vecs[21] = mk(2'b11, 4'd12, 4'd12, 2'b11, 4'd12, 16'h1111, 4'd12, 16'h2222, 16'h2222, 16'h2222, 16'h000C, 16'h000C);
        vecs[22] = mk(2'b11, 4'd12, 4'd12, 2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 16'h2222, 16'h2222, 16'h2222, 16'h2222);

        // ---------------- reset ----------------
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_data_b", rd_data_b, 32'h0);
        chk("rst_data_n", rd_data_n, 32'h0);
        chk("rst_pend_b", {30'h0, rd_pend_b}, 32'h0);
        chk("rst_busy_b", {16'h0, busy_b}, 32'h0);
        chk("rst_busy_n", {16'h0, busy_n}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // ---------------- table ----------------
        for (int i = 0; i < 23; i++) begin
            rd_en   = vecs[i].re;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            wr_en   = vecs[i].we;
            wr_addr = {vecs[i].wa1, vecs[i].wa0};
            wr_data = {vecs[i].wd1, vecs[i].wd0};
            tick();
            chk($sformatf("v%0d_byp_d0", i), {16'h0, rd_data_b[15:0]},  {16'h0, vecs[i].e0});
            chk($sformatf("v%0d_byp_d1", i), {16'h0, rd_data_b[31:16]}, {16'h0, vecs[i].e1});
            chk($sformatf("v%0d_nb_d0", i),  {16'h0, rd_data_n[15:0]},  {16'h0, vecs[i].n0});
            chk($sformatf("v%0d_nb_d1", i),  {16'h0, rd_data_n[31:16]}, {16'h0, vecs[i].n1});
            chk($sformatf("v%0d_pend", i),   {28'h0, rd_pend_n, rd_pend_b}, 32'h0);
        end
        idle_inputs();

        // ---------------- scoreboard ----------------
        issue_en = 1'b1; issue_addr = 4'd9;
        tick();
        issue_en = 1'b0;
        chk("sb_issue_busy_b", {16'h0, busy_b}, 32'h0000_0200);
        chk("sb_issue_busy_n", {16'h0, busy_n}, 32'h0000_0200);

        rd_en = 2'b01; rd_addr = {4'd0, 4'd9};
        tick();
        chk("sb_read_pend_b", {31'h0, rd_pend_b[0]}, 32'h1);
        chk("sb_read_pend_n", {31'h0, rd_pend_n[0]}, 32'h1);

        // Writeback and re-issue of addr 9 in one cycle, read alongside.
        wr_en = 2'b01; wr_addr = {4'd0, 4'd9}; wr_data = {16'h0, 16'h1111};
        issue_en = 1'b1; issue_addr = 4'd9;
        tick();
        issue_en = 1'b0; wr_en = '0; rd_en = '0;
        chk("sb_setclr_busy_b", {31'h0, busy_b[9]}, 32'h1);
        chk("sb_setclr_busy_n", {31'h0, busy_n[9]}, 32'h1);
        chk("sb_setclr_pend_b", {31'h0, rd_pend_b[0]}, 32'h0);
        chk("sb_setclr_pend_n", {31'h0, rd_pend_n[0]}, 32'h1);
        chk("sb_setclr_data_b", {16'h0, rd_data_b[15:0]}, 32'h1111);
        chk("sb_setclr_data_n", {16'h0, rd_data_n[15:0]}, 32'h0009);

        wr_en = 2'b10; wr_addr = {4'd9, 4'd0}; wr_data = {16'h2222, 16'h0};
        tick();
        wr_en = '0;
        chk("sb_clear_busy_b", {16'h0, busy_b}, 32'h0);
        chk("sb_clear_busy_n", {16'h0, busy_n}, 32'h0);

        // ---------------- async reset mid-operation ----------------
        wr_en = 2'b01; wr_addr = {4'd0, 4'd2}; wr_data = {16'h0, 16'hFFFF};
        issue_en = 1'b1; issue_addr = 4'd4;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
        tick();
        idle_inputs();
        chk("ar_pre_busy", {16'h0, busy_b}, 32'h0000_0010);
        chk("ar_pre_data", {16'h0, rd_data_b[15:0]}, 32'h0000_FFFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_data_b", rd_data_b, 32'h0);
        chk("ar_data_n", rd_data_n, 32'h0);
        chk("ar_busy_b", {16'h0, busy_b}, 32'h0);
        chk("ar_pend_b", {30'h0, rd_pend_b}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_en = 2'b11; rd_addr = {4'd13, 4'd2};
        tick();
        rd_en = '0;
        chk("ar_reg2_b",  {16'h0, rd_data_b[15:0]},  32'h0002);
        chk("ar_reg2_n",  {16'h0, rd_data_n[15:0]},  32'h0002);
        chk("ar_reg13_b", {16'h0, rd_data_b[31:16]}, 32'h01FF);
        chk("ar_busy_after", {16'h0, busy_b}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_regfile_nr2w

// File: doc/regfile_nr2w.md
Name: regfile_nr2w

Overview:
Parametrised general-purpose register file for the 16-bit ARM core: NUM_RD registered read ports and two write ports (ALU writeback and load/AES writeback).
Adds write-to-read bypass, deterministic same-address write priority, and a pending-write scoreboard for hazard detection.
Sits between decode (read and issue) and writeback (write and clear).

Parameters:
WIDTH, 16, data width of each register
DEPTH, 16, number of registers (power of two, ≥4); AW = $clog2(DEPTH)
NUM_RD, 2, number of read ports (1..4)
SP_IDX, 13, index of the stack-pointer register
SP_INIT, 16'h01FF, reset value of register SP_IDX (zero-extended or truncated to WIDTH)
BYPASS, 1, 1 = same-cycle write data is forwarded to read outputs; 0 = old contents are returned

Ports:
clk_i  input  1  clock, rising edge
reset_n_i  input  1  asynchronous, active-low reset
rd_en_i  input  NUM_RD  per-port read enable
rd_addr_i  input  NUM_RD*AW  packed read addresses; port k at [k*AW +: AW]
rd_data_o  output  NUM_RD*WIDTH  packed registered read data
rd_pend_o  output  NUM_RD  registered: addressed register had a pending write at capture
wr_en_i  input  2  write enables; bit 1 has priority
wr_addr_i  input  2*AW  packed write addresses
wr_data_i  input  2*WIDTH  packed write data
issue_en_i  input  1  marks issue_addr_i as awaiting writeback
issue_addr_i  input  AW  destination register of the issued instruction
busy_o  output  DEPTH  scoreboard pending bit per register

Behaviour:
- Reset (async assert, sync release expected):
  - reg[i] = i for i < SP_IDX; reg[SP_IDX] = SP_INIT; reg[i] = 0 for i > SP_IDX.
  - rd_data_o = 0, rd_pend_o = 0, busy_o = 0.
  - Asserting reset mid-operation discards in-flight writes and issues; no partial updates survive.
- Writes take effect at the rising edge when wr_en_i[j] = 1.
  - Both ports to the same address: port 1 data is stored; port 0 is dropped silently.
  - Different addresses: both are stored.
- Reads have 1-cycle latency.
  - rd_en_i[k] = 1: rd_data_o[k] captures reg[rd_addr k] at the edge.
  - rd_en_i[k] = 0: rd_data_o[k] and rd_pend_o[k] hold their previous values.
- Bypass (BYPASS = 1): a read that coincides with a write to the same address captures the write data; port 1 wins if both write ports match.
  - BYPASS = 0: the read captures the pre-write contents.
- Any number of read ports may use the same address; each returns identical data.
- Scoreboard:
  - issue_en_i sets busy[issue_addr_i].
  - Each wr_en_i[j] clears busy[wr_addr j].
  - Set and clear of the same address in the same cycle: set wins (a newer issue outstanding).
  - Issue to an already-busy register: stays busy. Clear of a non-busy register: no effect.
- rd_pend_o[k] is captured alongside rd_data_o[k] using the post-update busy view:
  - busy after the clear, ignoring a same-cycle issue, when BYPASS = 1;
  - busy before the clear when BYPASS = 0.
- busy_o is the registered pending vector; no combinational path from inputs.
- Out-of-range addresses cannot occur, since DEPTH is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants REG_W = 16, REG_DEPTH = 16, SP_IDX = 13, SP_INIT = 16'h01FF;
  - typedef reg_addr_t (logic [3:0]) and reg_data_t (logic [15:0]).
- One sub-module, regfile_scoreboard (busy vector with set/clear priority), instantiated once.
- Read muxes and bypass compare are generated per port with a generate loop inside regfile_nr2w.

Test Plan:
- Reset then read all 16 registers across ports 0/1 → reg i = i for i ≤ 12, reg13 = 16'h01FF, reg14 = reg15 = 0; rd_pend_o = 0.
- wr0 (addr 3, 16'hAAAA) and wr1 (addr 3, 16'h5555) in the same cycle, read addr 3 next cycle → 16'h5555.
- Same cycle: write addr 5 = 16'h1234 and read addr 5 on both ports.
  - BYPASS = 1 → both ports return 16'h1234.
  - BYPASS = 0 → both ports return 16'h0005; the following read returns 16'h1234.
- Read 16'hBEEF from addr 7, then hold rd_en_i = 0 for 3 cycles while writing addr 7 = 0 → rd_data_o stays 16'hBEEF.
- Scoreboard sequence:
  - issue addr 9 → busy_o[9] = 1 next cycle;
  - read addr 9 → rd_pend_o = 1;
  - same-cycle wr0 addr 9 plus issue addr 9 → busy stays 1;
  - wr1 addr 9 alone → busy_o[9] = 0.
- Assert reset_n_i low asynchronously mid-cycle after writing addr 2 = 16'hFFFF with busy_o[4] = 1 → outputs and busy clear immediately, without waiting for a clock edge; after release, reg2 reads 16'h0002.
